// File: rtl/data_table_arb_if.sv
// Requester-facing and table-facing signals of the data table arbiter, grouped for port passing.
// slave: arbiter view; master: requester/table (environment) view.
interface data_table_arb_if #(
   parameter int DIR_CNT = 4,
   parameter int A_WIDTH = 8,
   parameter int D_WIDTH = 16
);
   logic [DIR_CNT-1:0]         rd_req_i;
   logic [DIR_CNT*A_WIDTH-1:0] rd_addr_i;
   logic [DIR_CNT-1:0]         rd_gnt_o;
   logic [D_WIDTH-1:0]         rd_data_o;
   logic [DIR_CNT-1:0]         rd_data_val_o;
   logic [DIR_CNT-1:0]         wr_req_i;
   logic [DIR_CNT*A_WIDTH-1:0] wr_addr_i;
   logic [DIR_CNT*D_WIDTH-1:0] wr_data_i;
   logic [DIR_CNT-1:0]         wr_gnt_o;
   logic [A_WIDTH-1:0]         tbl_rd_addr_o;
   logic                       tbl_rd_en_o;
   logic [D_WIDTH-1:0]         tbl_rd_data_i;
   logic [A_WIDTH-1:0]         tbl_wr_addr_o;
   logic [D_WIDTH-1:0]         tbl_wr_data_o;
   logic                       tbl_wr_en_o;

   modport slave (
      input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, tbl_rd_data_i,
      output rd_gnt_o, rd_data_o, rd_data_val_o, wr_gnt_o,
             tbl_rd_addr_o, tbl_rd_en_o, tbl_wr_addr_o, tbl_wr_data_o, tbl_wr_en_o
   );

   modport master (
      output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, tbl_rd_data_i,
      input  rd_gnt_o, rd_data_o, rd_data_val_o, wr_gnt_o,
             tbl_rd_addr_o, tbl_rd_en_o, tbl_wr_addr_o, tbl_wr_data_o, tbl_wr_en_o
   );
endinterface

// File: rtl/data_table_arb.sv
// Independent round-robin read/write arbiters for a shared data table; combinational grant, table access next cycle.
// Read data returns RD_LATENCY+2 cycles after grant with a one-hot owner tag; requesters hold req until granted.
package hash_table;
   localparam int TABLE_ADDR_WIDTH = 8;
   typedef logic [15:0] ram_data_t;
endpackage

module data_table_arb #(
   parameter int DIR_CNT    = 4,
   parameter int RD_LATENCY = 2,
   parameter int A_WIDTH    = hash_table::TABLE_ADDR_WIDTH,
   parameter int D_WIDTH    = $bits(hash_table::ram_data_t)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   data_table_arb_if.slave bus
);
   localparam int PW = $clog2(DIR_CNT);
   localparam int PD = RD_LATENCY + 1;

   // Returns {found, index}; the nearest requester after 'last' wins because the scan runs farthest-first.
   function automatic logic [PW:0] rr_pick(input logic [DIR_CNT-1:0] req, input logic [PW-1:0] last);
      logic [PW:0]   pick;
      logic [PW-1:0] idx;
      pick = '0;
      for (int i = DIR_CNT; i >= 1; i--) begin
         idx = PW'((int'(last) + i) % DIR_CNT);
         if (req[idx]) pick = {1'b1, idx};
      end
      return pick;
   endfunction

   logic [PW-1:0]      rd_ptr, wr_ptr;
   logic [PW:0]        rd_pick, wr_pick;
   logic               rd_go, wr_go;
   logic [PW-1:0]      rd_sel, wr_sel;
   logic [A_WIDTH-1:0] tbl_rd_addr, tbl_wr_addr;
   logic [D_WIDTH-1:0] tbl_wr_data, rd_data;
   logic               tbl_rd_en, tbl_wr_en;
   logic [DIR_CNT-1:0] rd_val;
   logic [PD-1:0]      pipe_vld;
   logic [PW-1:0]      pipe_idx [PD];

   assign rd_pick = rr_pick(bus.rd_req_i, rd_ptr);
   assign wr_pick = rr_pick(bus.wr_req_i, wr_ptr);
   // Grants are suppressed while reset is held so requesters never see a phantom acceptance.
   assign rd_go   = rst_i & rd_pick[PW];
   assign wr_go   = rst_i & wr_pick[PW];
   assign rd_sel  = rd_pick[PW-1:0];
   assign wr_sel  = wr_pick[PW-1:0];

   assign bus.rd_gnt_o      = rd_go ? (DIR_CNT'(1) << rd_sel) : '0;
   assign bus.wr_gnt_o      = wr_go ? (DIR_CNT'(1) << wr_sel) : '0;
   assign bus.tbl_rd_addr_o = tbl_rd_addr;
   assign bus.tbl_rd_en_o   = tbl_rd_en;
   assign bus.tbl_wr_addr_o = tbl_wr_addr;
   assign bus.tbl_wr_data_o = tbl_wr_data;
   assign bus.tbl_wr_en_o   = tbl_wr_en;
   assign bus.rd_data_o     = rd_data;
   assign bus.rd_data_val_o = rd_val;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_ptr      <= PW'(DIR_CNT - 1);
         wr_ptr      <= PW'(DIR_CNT - 1);
         tbl_rd_addr <= '0;
         tbl_rd_en   <= 1'b0;
         tbl_wr_addr <= '0;
         tbl_wr_data <= '0;
         tbl_wr_en   <= 1'b0;
         rd_data     <= '0;
         rd_val      <= '0;
         pipe_vld    <= '0;
         for (int k = 0; k < PD; k++) pipe_idx[k] <= '0;
      end else begin
         tbl_rd_en <= rd_go;
         tbl_wr_en <= wr_go;
         if (rd_go) begin
            rd_ptr      <= rd_sel;
            tbl_rd_addr <= bus.rd_addr_i[rd_sel*A_WIDTH +: A_WIDTH];
         end
         if (wr_go) begin
            wr_ptr      <= wr_sel;
            tbl_wr_addr <= bus.wr_addr_i[wr_sel*A_WIDTH +: A_WIDTH];
            tbl_wr_data <= bus.wr_data_i[wr_sel*D_WIDTH +: D_WIDTH];
         end
         // Last stage lines up with tbl_rd_data_i of the read issued RD_LATENCY cycles earlier.
         pipe_vld    <= {pipe_vld[PD-2:0], rd_go};
         pipe_idx[0] <= rd_sel;
         for (int k = 1; k < PD; k++) pipe_idx[k] <= pipe_idx[k-1];
         rd_val <= pipe_vld[PD-1] ? (DIR_CNT'(1) << pipe_idx[PD-1]) : '0;
         if (pipe_vld[PD-1]) rd_data <= bus.tbl_rd_data_i;
      end
   end
endmodule

// File: tb/tb_data_table_arb.sv
// Bench for data_table_arb: randomized and directed requests checked against a transaction-level model.
module tb_data_table_arb;
   localparam int N  = 4;
   localparam int L  = 2;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int IW = $clog2(N);
   typedef logic [IW-1:0] idx_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   data_table_arb_if #(.DIR_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW)) bus ();
   data_table_arb #(.DIR_CNT(N), .RD_LATENCY(L), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
   );

   // Table model: data for a read issued in cycle M is presented throughout cycle M+L, junk otherwise.
   logic [DW-1:0] mem [1<<AW];
   logic          tv [L+1] = '{default: 1'b0};
   logic [AW-1:0] ta [L+1] = '{default: '0};
   always @(negedge clk_i) begin
      for (int k = L; k >= 1; k--) begin
         tv[k] = tv[k-1];
         ta[k] = ta[k-1];
      end
      tv[0] = bus.tbl_rd_en_o;
      ta[0] = bus.tbl_rd_addr_o;
      bus.tbl_rd_data_i = tv[L] ? mem[ta[L]] : DW'($urandom);
   end

   typedef struct { int due; idx_t idx; logic [AW-1:0] addr; } rd_t;
   rd_t           pend [$];
   int            checks = 0, fails = 0, cyc = 0;
   idx_t          rd_last, wr_last;
   logic [IW:0]   rpick, wpick;
   logic [N-1:0]  rreq, wreq, exp_rgnt, exp_wgnt, exp_val;
   logic [AW-1:0] raddr [N], waddr [N];
   logic [DW-1:0] wdata [N];
   logic          exp_ren, exp_wen;
   logic [AW-1:0] exp_raddr, exp_waddr;
   logic [DW-1:0] exp_wdat, exp_rdata;

   function automatic logic [IW:0] rr(input logic [N-1:0] req, input idx_t last);
      idx_t k;
      for (int i = 1; i <= N; i++) begin
         k = idx_t'((int'(last) + i) % N);
         if (req[k]) return {1'b1, k};
      end
      return '0;
   endfunction

   task automatic reset_model();
      rd_last = idx_t'(N - 1);
      wr_last = idx_t'(N - 1);
      pend.delete();
      rpick = '0; wpick = '0;
      exp_ren = 1'b0; exp_wen = 1'b0; exp_val = '0;
      exp_raddr = '0; exp_waddr = '0; exp_wdat = '0; exp_rdata = '0;
   endtask

   task automatic rand_addrs();
      for (int i = 0; i < N; i++) begin
         raddr[i] = AW'($urandom);
         waddr[i] = AW'($urandom);
         wdata[i] = DW'($urandom);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         bus.rd_addr_i[i*AW +: AW] = raddr[i];
         bus.wr_addr_i[i*AW +: AW] = waddr[i];
         bus.wr_data_i[i*DW +: DW] = wdata[i];
      end
      bus.rd_req_i = rreq;
      bus.wr_req_i = wreq;
      rpick    = rr(rreq, rd_last);
      wpick    = rr(wreq, wr_last);
      exp_rgnt = rpick[IW] ? (N'(1) << rpick[IW-1:0]) : '0;
      exp_wgnt = wpick[IW] ? (N'(1) << wpick[IW-1:0]) : '0;
   endtask

   task automatic advance();
      rd_t t;
      exp_ren = rpick[IW];
      exp_wen = wpick[IW];
      if (rpick[IW]) begin
         t.due = cyc + L + 2; t.idx = rpick[IW-1:0]; t.addr = raddr[rpick[IW-1:0]];
         pend.push_back(t);
         exp_raddr = t.addr;
         rd_last   = rpick[IW-1:0];
      end
      if (wpick[IW]) begin
         exp_waddr = waddr[wpick[IW-1:0]];
         exp_wdat  = wdata[wpick[IW-1:0]];
         wr_last   = wpick[IW-1:0];
      end
      @(posedge clk_i); #1;
      cyc++;
      exp_val = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_val   = N'(1) << pend[0].idx;
         exp_rdata = mem[pend[0].addr];
         void'(pend.pop_front());
      end
   endtask

   task automatic test_reset();
      rreq = '1; wreq = '1; rand_addrs(); apply();
      repeat (2) @(negedge clk_i);
      checks++; if (bus.rd_gnt_o !== '0) begin fails++; $display("FAIL reset_rd_gnt got %b expected 0", bus.rd_gnt_o); end
      checks++; if (bus.wr_gnt_o !== '0) begin fails++; $display("FAIL reset_wr_gnt got %b expected 0", bus.wr_gnt_o); end
      checks++; if (bus.tbl_rd_en_o !== 1'b0 || bus.tbl_wr_en_o !== 1'b0) begin fails++; $display("FAIL reset_tbl_en got rd=%b wr=%b expected 0", bus.tbl_rd_en_o, bus.tbl_wr_en_o); end
      checks++; if (bus.rd_data_val_o !== '0) begin fails++; $display("FAIL reset_val got %b expected 0", bus.rd_data_val_o); end
      checks++; if (bus.rd_data_o !== '0) begin fails++; $display("FAIL reset_rd_data got %h expected 0", bus.rd_data_o); end
      checks++; if (bus.tbl_rd_addr_o !== '0 || bus.tbl_wr_addr_o !== '0 || bus.tbl_wr_data_o !== '0) begin
         fails++; $display("FAIL reset_tbl_bus got ra=%h wa=%h wd=%h expected 0", bus.tbl_rd_addr_o, bus.tbl_wr_addr_o, bus.tbl_wr_data_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      reset_model();
   endtask

   task automatic test_rr_read();
      for (int c = 0; c < 12; c++) begin
         logic [N-1:0] seq;
         rreq = (c < 8) ? '1 : '0; wreq = '0; rand_addrs(); apply();
         seq = (c < 8) ? (N'(1) << (c % N)) : '0;
         @(negedge clk_i);
         checks++; if (bus.rd_gnt_o !== seq || bus.rd_gnt_o !== exp_rgnt) begin fails++; $display("FAIL rr_rd_gnt c=%0d got %b expected %b", c, bus.rd_gnt_o, seq); end
         checks++; if (bus.tbl_rd_en_o !== (c >= 1 && c <= 8)) begin fails++; $display("FAIL rr_tbl_rd_en c=%0d got %b expected %b", c, bus.tbl_rd_en_o, (c >= 1 && c <= 8)); end
         checks++; if (exp_ren && bus.tbl_rd_addr_o !== exp_raddr) begin fails++; $display("FAIL rr_tbl_rd_addr c=%0d got %h expected %h", c, bus.tbl_rd_addr_o, exp_raddr); end
         checks++; if (bus.rd_data_val_o !== exp_val) begin fails++; $display("FAIL rr_val c=%0d got %b expected %b", c, bus.rd_data_val_o, exp_val); end
         checks++; if (bus.rd_data_o !== exp_rdata) begin fails++; $display("FAIL rr_rd_data c=%0d got %h expected %h", c, bus.rd_data_o, exp_rdata); end
         advance();
      end
   endtask

   task automatic test_single_read();
      rand_addrs();
      raddr[2] = 8'h15;
      for (int c = 0; c < 7; c++) begin
         logic [N-1:0] want;
         rreq = (c == 0) ? 4'b0100 : 4'b0000; wreq = '0; apply();
         want = (c == 4) ? 4'b0100 : 4'b0000;
         @(negedge clk_i);
         if (c == 0) begin
            checks++; if (bus.rd_gnt_o !== 4'b0100) begin fails++; $display("FAIL single_gnt got %b expected 0100", bus.rd_gnt_o); end
         end
         checks++; if (bus.rd_data_val_o !== want || bus.rd_data_val_o !== exp_val) begin fails++; $display("FAIL single_val c=%0d got %b expected %b", c, bus.rd_data_val_o, want); end
         if (c >= 4) begin
            checks++; if (bus.rd_data_o !== 16'hABCD) begin fails++; $display("FAIL single_data c=%0d got %h expected abcd", c, bus.rd_data_o); end
         end
         advance();
      end
   endtask

   task automatic test_rd_wr_parallel();
      rand_addrs();
      raddr[0] = 8'h40; waddr[3] = 8'h40; wdata[3] = 16'h1234;
      rreq = 4'b0011; wreq = 4'b1000; apply();
      @(negedge clk_i);
      checks++; if (bus.rd_gnt_o !== 4'b0001 || bus.rd_gnt_o !== exp_rgnt) begin fails++; $display("FAIL par_rd_gnt got %b expected 0001", bus.rd_gnt_o); end
      checks++; if (bus.wr_gnt_o !== 4'b1000 || bus.wr_gnt_o !== exp_wgnt) begin fails++; $display("FAIL par_wr_gnt got %b expected 1000", bus.wr_gnt_o); end
      advance();
      for (int c = 1; c < 6; c++) begin
         rreq = '0; wreq = '0; apply();
         @(negedge clk_i);
         if (c == 1) begin
            checks++; if (bus.tbl_rd_en_o !== 1'b1 || bus.tbl_wr_en_o !== 1'b1) begin fails++; $display("FAIL par_tbl_en got rd=%b wr=%b expected 1 1", bus.tbl_rd_en_o, bus.tbl_wr_en_o); end
            checks++; if (bus.tbl_rd_addr_o !== 8'h40 || bus.tbl_wr_addr_o !== 8'h40 || bus.tbl_wr_data_o !== 16'h1234) begin
               fails++; $display("FAIL par_tbl_bus got ra=%h wa=%h wd=%h expected 40 40 1234", bus.tbl_rd_addr_o, bus.tbl_wr_addr_o, bus.tbl_wr_data_o);
            end
         end
         checks++; if (bus.rd_data_val_o !== exp_val || bus.rd_data_o !== exp_rdata) begin
            fails++; $display("FAIL par_return c=%0d got %b/%h expected %b/%h", c, bus.rd_data_val_o, bus.rd_data_o, exp_val, exp_rdata);
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] order [4];
      order = '{4'b1000, 4'b0010, 4'b0001, 4'b0100};
      rand_addrs();
      for (int c = 0; c < 9; c++) begin
         rreq = (c < 4) ? order[c] : '0; wreq = '0; apply();
         @(negedge clk_i);
         if (c < 4) begin
            checks++; if (bus.rd_gnt_o !== order[c]) begin fails++; $display("FAIL b2b_gnt c=%0d got %b expected %b", c, bus.rd_gnt_o, order[c]); end
         end else if (c < 8) begin
            checks++; if (bus.rd_data_val_o !== order[c-4]) begin fails++; $display("FAIL b2b_order c=%0d got %b expected %b", c, bus.rd_data_val_o, order[c-4]); end
         end
         checks++; if (bus.rd_data_val_o !== exp_val || bus.rd_data_o !== exp_rdata) begin
            fails++; $display("FAIL b2b_return c=%0d got %b/%h expected %b/%h", c, bus.rd_data_val_o, bus.rd_data_o, exp_val, exp_rdata);
         end
         advance();
      end
   endtask

   task automatic test_reset_flush();
      rand_addrs();
      rreq = 4'b0010; wreq = '0; apply(); advance();
      rreq = 4'b0100; apply(); advance();
      rreq = '1; apply();
      #2 rst_i = 1'b0;
      reset_model();
      @(negedge clk_i);
      checks++; if (bus.rd_gnt_o !== '0 || bus.tbl_rd_en_o !== 1'b0) begin fails++; $display("FAIL flush_in_reset got gnt=%b en=%b expected 0 0", bus.rd_gnt_o, bus.tbl_rd_en_o); end
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b1;
      for (int c = 0; c < 7; c++) begin
         rreq = (c == 0) ? '1 : '0; apply();
         @(negedge clk_i);
         if (c == 0) begin
            checks++; if (bus.rd_gnt_o !== 4'b0001) begin fails++; $display("FAIL flush_first_gnt got %b expected 0001", bus.rd_gnt_o); end
         end
         if (c < 4) begin
            checks++; if (bus.rd_data_val_o !== '0) begin fails++; $display("FAIL flush_stale_val c=%0d got %b expected 0", c, bus.rd_data_val_o); end
         end
         checks++; if (bus.rd_data_val_o !== exp_val) begin fails++; $display("FAIL flush_val c=%0d got %b expected %b", c, bus.rd_data_val_o, exp_val); end
         advance();
      end
   endtask

   task automatic test_fairness();
      int waited;
      bit got;
      rand_addrs();
      rreq = '0; wreq = 4'b0010; apply();
      @(negedge clk_i);
      checks++; if (bus.wr_gnt_o !== 4'b0010) begin fails++; $display("FAIL fair_setup got %b expected 0010", bus.wr_gnt_o); end
      advance();
      waited = 0; got = 1'b0;
      for (int c = 0; c < N; c++) begin
         wreq = '1; rand_addrs(); apply();
         @(negedge clk_i);
         checks++; if (bus.wr_gnt_o !== exp_wgnt) begin fails++; $display("FAIL fair_wr_gnt c=%0d got %b expected %b", c, bus.wr_gnt_o, exp_wgnt); end
         checks++; if (bus.tbl_wr_en_o !== exp_wen || (exp_wen && (bus.tbl_wr_addr_o !== exp_waddr || bus.tbl_wr_data_o !== exp_wdat))) begin
            fails++; $display("FAIL fair_tbl_wr c=%0d got %b/%h/%h expected %b/%h/%h", c, bus.tbl_wr_en_o, bus.tbl_wr_addr_o, bus.tbl_wr_data_o, exp_wen, exp_waddr, exp_wdat);
         end
         if (!got) begin
            waited++;
            got = bus.wr_gnt_o[1];
         end
         advance();
      end
      checks++; if (!got || waited > N) begin fails++; $display("FAIL fair_bound got granted=%0d after %0d cycles expected within %0d", got, waited, N); end
      wreq = '0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 306; c++) begin
         rreq = (c < 300) ? N'($urandom) : '0;
         wreq = (c < 300) ? N'($urandom) : '0;
         rand_addrs(); apply();
         @(negedge clk_i);
         checks++; if (bus.rd_gnt_o !== exp_rgnt) begin fails++; $display("FAIL rand_rd_gnt c=%0d req=%b got %b expected %b", c, rreq, bus.rd_gnt_o, exp_rgnt); end
         checks++; if (bus.wr_gnt_o !== exp_wgnt) begin fails++; $display("FAIL rand_wr_gnt c=%0d req=%b got %b expected %b", c, wreq, bus.wr_gnt_o, exp_wgnt); end
         checks++; if (bus.tbl_rd_en_o !== exp_ren || (exp_ren && bus.tbl_rd_addr_o !== exp_raddr)) begin
            fails++; $display("FAIL rand_tbl_rd c=%0d got %b/%h expected %b/%h", c, bus.tbl_rd_en_o, bus.tbl_rd_addr_o, exp_ren, exp_raddr);
         end
         checks++; if (bus.tbl_wr_en_o !== exp_wen || (exp_wen && (bus.tbl_wr_addr_o !== exp_waddr || bus.tbl_wr_data_o !== exp_wdat))) begin
            fails++; $display("FAIL rand_tbl_wr c=%0d got %b/%h/%h expected %b/%h/%h", c, bus.tbl_wr_en_o, bus.tbl_wr_addr_o, bus.tbl_wr_data_o, exp_wen, exp_waddr, exp_wdat);
         end
         checks++; if (bus.rd_data_val_o !== exp_val || bus.rd_data_o !== exp_rdata) begin
            fails++; $display("FAIL rand_return c=%0d got %b/%h expected %b/%h", c, bus.rd_data_val_o, bus.rd_data_o, exp_val, exp_rdata);
         end
         advance();
      end
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
      mem[8'h15] = 16'hABCD;
      rreq = '0; wreq = '0;
      for (int i = 0; i < N; i++) begin
         raddr[i] = '0; waddr[i] = '0; wdata[i] = '0;
      end
      reset_model();
      test_reset();
      test_rr_read();
      test_single_read();
      test_rd_wr_parallel();
      test_back_to_back();
      test_reset_flush();
      test_fairness();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
